// File: rtl/ds_burst_sequencer.sv
// ds_burst_sequencer: gates a table-driven sample source and frames
// a burst of whole table periods as an sop/eop-marked output stream.
module ds_burst_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_periods,
  input  logic             src_valid,
  input  logic [31:0]      src_data,
  output logic             src_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             overrun
);

  localparam int TW = CNT_W + ADDR_W;
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] total_q, total_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          vld_q, vld_d;
  logic [31:0]   data_q, data_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          done_q, done_d;
  logic          abt_q, abt_d;
  logic          ovr_q, ovr_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          last_beat;

  assign last_beat = (cnt_q == total_q - T_ONE);

  // Next-state: sequencing, beat capture/drop and sticky status.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    vld_d   = vld_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    abt_d   = abt_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    if (vld_q && out_ready) vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (n_periods != '0)) begin
          total_d = {n_periods, {ADDR_W{1'b0}}};
          cnt_d   = '0;
          abt_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DRAIN;
          drain_d = '0;
          abt_d   = 1'b1;
        end else if (src_valid) begin
          cnt_d = cnt_q + T_ONE;
          if (vld_q && !out_ready) begin
            ovr_d = 1'b1;
          end else begin
            vld_d  = 1'b1;
            data_d = src_data;
            sop_d  = (cnt_q == '0);
            eop_d  = last_beat;
          end
          if (last_beat) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          drain_d = '0;
          abt_d   = 1'b1;
        end else if (drain_q == D_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + D_ONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_DRAIN;
          drain_d = '0;
          abt_d   = 1'b1;
        end else if (!vld_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_d   = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      total_q <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      ovr_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
      ovr_q   <= ovr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign src_enable = en_q;
  assign out_valid  = vld_q;
  assign out_data   = data_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = abt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ds_burst_sequencer.sv
// tb_ds_burst_sequencer: random + directed bursts, one-slot
// transaction model feeding a scoreboard checked by a monitor.
module tb_ds_burst_sequencer;

  localparam int ADDR_W = 4;
  localparam int CNT_W = 16;
  localparam int DRAIN_CYC = 4;
  localparam int M = 1 << ADDR_W;

  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic abort = 0;
  logic [CNT_W-1:0] n_periods = '0;
  logic src_valid = 0;
  logic [31:0] src_data = '0;
  logic out_ready = 0;
  logic src_enable, out_valid, out_sop, out_eop;
  logic busy, done, aborted, overrun;
  logic [31:0] out_data;

  ds_burst_sequencer #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_periods(n_periods), .src_valid(src_valid),
    .src_data(src_data), .src_enable(src_enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .busy(busy), .done(done), .aborted(aborted),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic sop;
    logic eop;
  } beat_t;

  beat_t expq[$];
  int total_c = 0;
  int bad_c = 0;
  int beats_seen = 0, sop_seen = 0, eop_seen = 0, done_cnt = 0;

  bit pend = 0, mrun = 0, mbusy = 0, m_abt = 0, m_ovr = 0;
  int k = 0, mtot = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_c++;
    if (act !== exp) begin
      bad_c++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted beat against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total_c++;
          bad_c++;
          $display("FAIL unexpected_beat: got %0h want none", out_data);
        end else begin
          e = expq.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_sop", out_sop, e.sop);
          chk("beat_eop", out_eop, e.eop);
        end
        beats_seen++;
        sop_seen += out_sop;
        eop_seen += out_eop;
      end
      if (done) done_cnt++;
    end
  end

  // One cycle of stimulus; the model treats the output as a
  // single slot that a new beat may fill only if it is empty
  // or being drained in the same cycle.
  task automatic step(bit sv, logic [31:0] d, bit rdy, bit st,
                      logic [CNT_W-1:0] n, bit ab);
    bit acc, cap;
    src_valid = sv;
    src_data = d;
    out_ready = rdy;
    start = st;
    n_periods = n;
    abort = ab;
    acc = pend && rdy;
    cap = 0;
    if (mrun) begin
      if (ab) begin
        mrun = 0;
        m_abt = 1;
      end else if (sv) begin
        if (pend && !rdy) m_ovr = 1;
        else begin
          expq.push_back({d, k == 0, k == mtot - 1});
          cap = 1;
        end
        k++;
        if (k == mtot) mrun = 0;
      end
    end else if (mbusy && ab) begin
      m_abt = 1;
    end else if (!mbusy && st && n != 0) begin
      mrun = 1;
      mbusy = 1;
      k = 0;
      mtot = int'(n) * M;
      m_abt = 0;
      m_ovr = 0;
    end
    if (cap) pend = 1;
    else if (acc) pend = 0;
    @(posedge clk);
    #1;
    chk("aborted", aborted, m_abt);
    chk("overrun", overrun, m_ovr);
    chk("out_valid", out_valid, pend);
    start = 0;
    abort = 0;
    src_valid = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0);
  endtask

  task automatic wait_done(output int cyc);
    bit found;
    found = 0;
    cyc = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(0, 0, 1, 0, 0, 0);
      cyc++;
      if (done) found = 1;
    end
    total_c++;
    if (!found) begin
      bad_c++;
      $display("FAIL done_timeout: got none want pulse");
    end
    mbusy = 0;
    chk("busy_after_done", busy, 0);
  endtask

  int b0, s0, e0, d0, cyc;

  task automatic snap();
    b0 = beats_seen;
    s0 = sop_seen;
    e0 = eop_seen;
    d0 = done_cnt;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", src_enable, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_flags", {done, aborted, overrun, out_sop, out_eop}, 0);
    reset = 0;
    idle(2);

    // Two periods, sparse source, ready always high.
    snap();
    step(0, 0, 1, 1, 2, 0);
    chk("t1_busy", busy, 1);
    chk("t1_en", src_enable, 1);
    for (int b = 0; b < 2 * M; b++) begin
      idle(32);
      step(1, $urandom, 1, 0, 0, 0);
      if (b == 2 * M - 1) chk("t1_en_drop", src_enable, 0);
      else chk("t1_en_hold", src_enable, 1);
    end
    wait_done(cyc);
    chk("t1_drain_len", cyc >= DRAIN_CYC + 1, 1);
    idle(3);
    chk("t1_beats", beats_seen - b0, 2 * M);
    chk("t1_sops", sop_seen - s0, 1);
    chk("t1_eops", eop_seen - e0, 1);
    chk("t1_dones", done_cnt - d0, 1);

    // Zero-period start is ignored.
    snap();
    step(0, 0, 1, 1, 0, 0);
    chk("t2_busy", busy, 0);
    chk("t2_en", src_enable, 0);
    idle(8);
    chk("t2_busy_late", busy, 0);
    chk("t2_dones", done_cnt - d0, 0);

    // Downstream stall causes overrun; framing still completes.
    snap();
    step(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 43; i++)
      step(i < M, $urandom, !(i >= 3 && i < 43), 0, 0, 0);
    chk("t3_en", src_enable, 0);
    chk("t3_ovr", overrun, 1);
    wait_done(cyc);
    idle(2);
    chk("t3_eops", eop_seen - e0, 0);
    chk("t3_dones", done_cnt - d0, 1);

    // Abort after beat 5 of a three-period burst.
    snap();
    step(0, 0, 1, 1, 3, 0);
    chk("t4_ovr_clr", overrun, 0);
    for (int b = 0; b < 6; b++) begin
      step(1, $urandom, 1, 0, 0, 0);
      idle(1);
    end
    step(0, 0, 1, 0, 0, 1);
    chk("t4_abt", aborted, 1);
    chk("t4_en", src_enable, 0);
    for (int i = 0; i < 3; i++) step(1, $urandom, 1, 0, 0, 0);
    wait_done(cyc);
    idle(2);
    chk("t4_beats", beats_seen - b0, 6);
    chk("t4_eops", eop_seen - e0, 0);
    chk("t4_dones", done_cnt - d0, 1);

    // Start while busy is ignored; a new burst clears sticky bits.
    snap();
    step(0, 0, 1, 1, 1, 0);
    chk("t5_abt_clr", aborted, 0);
    for (int b = 0; b < 4; b++) step(1, $urandom, 1, 0, 0, 0);
    step(0, 0, 1, 1, 5, 0);
    for (int b = 4; b < M; b++) step(1, $urandom, 1, 0, 0, 0);
    wait_done(cyc);
    idle(2);
    chk("t5_beats", beats_seen - b0, M);
    chk("t5_sops", sop_seen - s0, 1);
    chk("t5_eops", eop_seen - e0, 1);

    // Random traffic: sparse source, random backpressure, rare abort.
    for (int r = 0; r < 6; r++) begin
      step(0, 0, 1, 1, CNT_W'($urandom_range(1, 2)), 0);
      for (int i = 0; i < 1000 && mrun; i++)
        step($urandom % 3 == 0, $urandom, $urandom % 4 != 0, 0, 0,
             $urandom % 150 == 0);
      total_c++;
      if (mrun) begin
        bad_c++;
        $display("FAIL rand_burst_end: got running want finished");
        mrun = 0;
      end
      wait_done(cyc);
    end

    // Reset mid-run clears everything at once.
    step(0, 0, 0, 1, 1, 0);
    for (int b = 0; b < 3; b++) step(1, $urandom, 0, 0, 0, 0);
    reset = 1;
    #1;
    chk("rr_valid", out_valid, 0);
    chk("rr_busy", busy, 0);
    chk("rr_en", src_enable, 0);
    chk("rr_data", out_data, 0);
    chk("rr_flags", {done, aborted, overrun, out_sop, out_eop}, 0);
    expq.delete();
    pend = 0;
    mrun = 0;
    mbusy = 0;
    m_abt = 0;
    m_ovr = 0;
    idle(2);
    reset = 0;
    idle(3);
    chk("rr_idle", busy, 0);
    snap();
    step(0, 0, 1, 1, 1, 0);
    chk("rr_restart", busy, 1);
    for (int b = 0; b < M; b++) step(1, $urandom, 1, 0, 0, 0);
    wait_done(cyc);
    idle(2);
    chk("rr_beats", beats_seen - b0, M);
    chk("rr_eops", eop_seen - e0, 1);

    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total_c, bad_c);
    $finish;
  end

endmodule
